// File: rtl/q2_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : q2_sequencer                                                 |
// | Description : Q2 state/phase sequencer. It steps each instruction through  |
// |               FETCH, optional LOAD/DEREF, EXEC and the twelve serial ALU   |
// |               shift states. Each state takes three phases: settle, write   |
// |               and hold. It also provides front-panel run/stop control and  |
// |               halt parking.                                                |
// | Option      : Q2_SEQ_STEP_EN adds the step_sw single-instruction control.  |
// | Ports       : clk, rst_n       clock, synchronous active-low reset         |
// |               op1,op2,op5      O-register bits used for sequencing         |
// |               op3,op4          O-register bits, not used here              |
// |               halt             decoder halt strobe (EXEC, write phase)     |
// |               run_sw, stop_sw  debounced front-panel switch levels         |
// |               step_sw          debounced single-step switch (optional)     |
// |               s0..s3           state code, s0 = LSB                        |
// |               ws               write strobe, high in the write phase only  |
// |               running          high while instructions are sequenced       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module q2_sequencer (
  input  logic clk,
  input  logic rst_n,
  input  logic op1,
  input  logic op2,
  input  logic op3,
  input  logic op4,
  input  logic op5,
  input  logic halt,
  input  logic run_sw,
  input  logic stop_sw,
`ifdef Q2_SEQ_STEP_EN
  input  logic step_sw,
`endif
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic ws,
  output logic running
);

  localparam logic [3:0] c_FETCH = 4'b0000;
  localparam logic [3:0] c_LOAD  = 4'b0001;
  localparam logic [3:0] c_DEREF = 4'b0010;
  localparam logic [3:0] c_EXEC  = 4'b0011;
  localparam logic [3:0] c_ALU0  = 4'b0100;

  typedef enum logic [1:0] {
    PH_SETTLE = 2'd0,
    PH_WRITE  = 2'd1,
    PH_HOLD   = 2'd2
  } phase_t;

  logic [3:0] r_state;
  phase_t     r_phase;
  logic       r_ws;
  logic       r_running;
  logic       r_stop_pend;
  logic       r_run_q;

  logic [3:0] w_next;
  logic       w_run_edge;
  logic       w_step_edge;
  logic       w_park;

  // op3/op4 are part of the O-register bus but carry no sequencing meaning.
  logic       w_unused_ops;
  assign w_unused_ops = op3 ^ op4;

  assign w_run_edge = run_sw & ~r_run_q;

`ifdef Q2_SEQ_STEP_EN
  logic r_step_q;
  assign w_step_edge = step_sw & ~r_step_q;

  always_ff @(posedge clk) begin
    if (!rst_n) r_step_q <= 1'b0;
    else        r_step_q <= step_sw;
  end
`else
  assign w_step_edge = 1'b0;
`endif

  // Successor state. Evaluated during the hold phase, when the op bits
  // written at the end of FETCH P1 are already valid.
  always_comb begin
    w_next = r_state + 4'd1;  // ALU chain; ALU11 (1111) wraps to FETCH
    case (r_state)
      c_FETCH: w_next = op2 ? c_LOAD : (op1 ? c_DEREF : c_EXEC);
      c_LOAD:  w_next = op1 ? c_DEREF : c_EXEC;
      c_DEREF: w_next = c_EXEC;
      c_EXEC:  w_next = op5 ? c_FETCH : c_ALU0;
      default: w_next = r_state + 4'd1;
    endcase
  end

  // Parking only happens on the way into FETCH, so a stop request never
  // cuts an instruction short. A stop level present in that same hold
  // cycle counts as well.
  assign w_park = (w_next == c_FETCH) & (r_stop_pend | stop_sw);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= c_FETCH;
      r_phase     <= PH_SETTLE;
      r_ws        <= 1'b0;
      r_running   <= 1'b0;
      r_stop_pend <= 1'b0;
      r_run_q     <= 1'b0;
    end else begin
      r_run_q <= run_sw;
      if (r_running) begin
        if (stop_sw)
          r_stop_pend <= 1'b1;
        if ((r_phase == PH_WRITE) && halt)
          r_stop_pend <= 1'b1;
        case (r_phase)
          PH_SETTLE: begin
            r_phase <= PH_WRITE;
            r_ws    <= 1'b1;
          end
          PH_WRITE: begin
            r_phase <= PH_HOLD;
            r_ws    <= 1'b0;
          end
          PH_HOLD: begin
            r_phase <= PH_SETTLE;
            r_ws    <= 1'b0;
            r_state <= w_next;
            if (w_park) begin
              r_running   <= 1'b0;
              r_stop_pend <= 1'b0;
            end
          end
          default: begin
            r_phase <= PH_SETTLE;
            r_ws    <= 1'b0;
          end
        endcase
      end else begin
        // Parked: sitting in FETCH P0 with the phase counter frozen.
        r_ws <= 1'b0;
        if (w_run_edge && !stop_sw) begin
          r_running <= 1'b1;
        end else if (w_step_edge && !stop_sw) begin
          // Single step: pre-arm the stop so the next FETCH entry parks.
          r_running   <= 1'b1;
          r_stop_pend <= 1'b1;
        end
      end
    end
  end

  assign s0      = r_state[0];
  assign s1      = r_state[1];
  assign s2      = r_state[2];
  assign s3      = r_state[3];
  assign ws      = r_ws;
  assign running = r_running;

endmodule
`default_nettype wire
